arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter: WIDTH, 32, bit width of each data channel.
REQ-002 Parameter: N, 4, number of input channels; legal range 2..16.
REQ-003 Derived localparam: SELW = clog2(N); not overridable.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port: in_valid  input  N  per-channel beat offered.
REQ-008 Port: in_ready  output  N  per-channel beat accepted this cycle.
REQ-009 Port: out_data  output  WIDTH  registered selected beat.
REQ-010 Port: out_sel  output  SELW  registered index of the channel that supplied out_data.
REQ-011 Port: out_valid  output  1  out_data/out_sel hold a beat.
REQ-012 Port: out_ready  input  1  downstream accepts beat.

Function
REQ-013 Output stage SHALL be one register slot; states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 Slot free condition: free = !out_valid || out_ready.
REQ-015 When free and any in_valid set, arbiter SHALL grant exactly one channel g; in_ready SHALL be one-hot at bit g in the same cycle, combinationally.
REQ-016 When not free, or no in_valid set, in_ready SHALL be all zero.
REQ-017 On a grant, at the next edge: out_data <= channel g data, out_sel <= g, out_valid <= 1; latency 1 cycle.
REQ-018 On free with no request: if out_valid && out_ready, out_valid <= 0; out_data/out_sel keep last value.
REQ-019 Simultaneous drain and grant (FULL, out_ready=1, request present) SHALL replace the beat in the same edge; sustained throughput 1 beat/cycle.
REQ-020 FULL with out_ready=0: out_data, out_sel, out_valid SHALL stay stable (no change) until accepted.
REQ-021 A beat is transferred upstream only when in_valid[i] && in_ready[i]; non-granted channels are not consumed.
REQ-022 Transitions: EMPTY->FULL on grant; FULL->EMPTY on out_ready with no grant; FULL->FULL on grant+drain or stall; EMPTY->EMPTY otherwise.
REQ-023 Grant decision SHALL depend only on in_valid, free, and the priority pointer; never on in_data.

Reset
REQ-024 While rst=1 at an edge: out_valid <= 0, out_data <= 0, out_sel <= 0, priority pointer <= 0.
REQ-025 in_ready SHALL be all zero while rst=1.
REQ-026 Reset mid-operation SHALL discard any held beat; no grant occurs in a reset cycle.

Configuration
REQ-027 Macro ARB_MUX_RR_EN selects arbitration policy.
REQ-028 With ARB_MUX_RR_EN defined: round-robin; search starts at pointer p, first valid at index p, p+1, ... wrapping N-1->0 wins; on grant g, pointer <= (g+1) mod N.
REQ-029 Without ARB_MUX_RR_EN: fixed priority, lowest valid index wins; pointer register SHALL be absent and out_sel behaviour otherwise identical.

Verification
REQ-030 Reset: rst=1 two cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_sel=0.
REQ-031 Single beat: N=4, in_valid=0100, in_data ch2=0xDEADBEEF, out_ready=1 -> in_ready=0100 same cycle; next cycle out_valid=1, out_sel=2, out_data=0xDEADBEEF; following cycle out_valid=0.
REQ-032 Stall: out_valid=1, out_ready=0 for 3 cycles, in_valid=1111 -> in_ready=0000, out_data/out_sel unchanged all 3 cycles.
REQ-033 RR fairness (macro defined): in_valid=1111 held, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 (wrap-around); without macro -> 0 every cycle.
REQ-034 Back-to-back: alternating in_valid=0001/1000, out_ready=1 -> one beat per cycle, out_valid continuously 1, out_sel alternates 0,3.
REQ-035 Reset mid-stream: rst=1 while FULL with out_sel=3 -> next cycle out_valid=0, out_sel=0; RR pointer 0, so first grant with in_valid=1111 is channel 0.

Source files
------------

// File: rtl/arb_mux.sv
// N-channel arbitrating mux into a single registered output slot.
// Define ARB_MUX_RR_EN for round-robin arbitration; fixed priority otherwise.
module arb_mux #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]  chan [N];
    logic              free;
    logic              grant;
    logic              found;
    logic [SELW-1:0]   grant_idx;

`ifdef ARB_MUX_RR_EN
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [SELW:0]     pos;
`endif

    always_comb begin
        for (int i = 0; i < N; i++) begin
            chan[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Request-only arbitration: data never influences the winner
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
`ifdef ARB_MUX_RR_EN
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr_q} + (SELW+1)'(k);
            if (pos >= (SELW+1)'(N)) begin
                pos = pos - (SELW+1)'(N);
            end
            if (!found && in_valid[pos[SELW-1:0]]) begin
                found     = 1'b1;
                grant_idx = pos[SELW-1:0];
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (!found && in_valid[i]) begin
                found     = 1'b1;
                grant_idx = SELW'(i);
            end
        end
`endif
    end

    always_comb begin
        free     = (state_q == EMPTY) || out_ready;
        grant    = free && found && !rst;
        in_ready = '0;
        state_d  = state_q;
        data_d   = data_q;
        sel_d    = sel_q;
        if (grant) begin
            in_ready[grant_idx] = 1'b1;
            state_d             = FULL;
            data_d              = chan[grant_idx];
            sel_d               = grant_idx;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

`ifdef ARB_MUX_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
`ifdef ARB_MUX_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
`ifdef ARB_MUX_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux (N=4, WIDTH=32); expectations follow
// the ARB_MUX_RR_EN setting of the build.
module tb_arb_mux;

    localparam int WIDTH = 32;
    localparam int N     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ch [N];

    int n_checks = 0;
    int n_fail   = 0;

    assign in_data = {ch[3], ch[2], ch[1], ch[0]};

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        ch[0] = 32'h0000_00A0; ch[1] = 32'h0000_00A1;
        ch[2] = 32'h0000_00A2; ch[3] = 32'h0000_00A3;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready0 got=%b exp=0000", in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready got=%b exp=0000", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got=%b exp=0", out_valid);
        end
        n_checks++;
        if (out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data got=%h exp=0", out_data);
        end
        n_checks++;
        if (out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_sel got=%0d exp=0", out_sel);
        end
        rst      = 1'b0;
        in_valid = 4'b0000;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_beat();
        ch[2]     = 32'hDEAD_BEEF;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ready got=%b exp=0100", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 4'b0000;
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_beat got v=%b s=%0d d=%h exp v=1 s=2 d=deadbeef",
                     out_valid, out_sel, out_data);
        end
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_idle_ready got=%b exp=0000", in_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_drain got v=%b d=%h exp v=0 d=deadbeef",
                     out_valid, out_data);
        end
    endtask

    task automatic test_stall();
        ch[0]     = 32'h1111_1111;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        ch[0]     = 32'h2222_2222;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall_ready[%0d] got=%b exp=0000", c, in_ready);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'h1111_1111) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got v=%b s=%0d d=%h exp v=1 s=0 d=11111111",
                         c, out_valid, out_sel, out_data);
            end
        end
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_rr_fairness();
        logic [1:0] exp_sel;
        logic [3:0] exp_rdy;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) ch[i] = 32'hA000_0000 + 32'(i);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
`ifdef ARB_MUX_RR_EN
            exp_sel = 2'(c % 4);
`else
            exp_sel = 2'd0;
`endif
            exp_rdy = 4'b0001 << exp_sel;
            #1;
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rr_ready[%0d] got=%b exp=%b", c, in_ready, exp_rdy);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel ||
                out_data !== 32'hA000_0000 + 32'(exp_sel)) begin
                n_fail++;
                $display("FAIL rr_sel[%0d] got v=%b s=%0d d=%h exp v=1 s=%0d",
                         c, out_valid, out_sel, out_data, exp_sel);
            end
        end
        in_valid = 4'b0000;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_sel;
        ch[0]     = 32'h0000_C0C0;
        ch[3]     = 32'h0000_3333;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            exp_sel  = (c % 2 == 0) ? 2'd0 : 2'd3;
            in_valid = (c % 2 == 0) ? 4'b0001 : 4'b1000;
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel ||
                out_data !== ((exp_sel == 2'd0) ? 32'h0000_C0C0 : 32'h0000_3333)) begin
                n_fail++;
                $display("FAIL b2b[%0d] got v=%b s=%0d d=%h exp v=1 s=%0d",
                         c, out_valid, out_sel, out_data, exp_sel);
            end
        end
        in_valid = 4'b0000;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        ch[3]     = 32'h3333_0003;
        in_valid  = 4'b1000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL midrst_pre got v=%b s=%0d exp v=1 s=3", out_valid, out_sel);
        end
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_ready got=%b exp=0000", in_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_clear got v=%b s=%0d d=%h exp v=0 s=0 d=0",
                     out_valid, out_sel, out_data);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_grant got=%b exp=0001", in_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== ch[0]) begin
            n_fail++;
            $display("FAIL midrst_first got v=%b s=%0d d=%h exp v=1 s=0 d=%h",
                     out_valid, out_sel, out_data, ch[0]);
        end
        in_valid = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_stall();
        test_rr_fairness();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
